// File: rtl/mont_pkg.sv
// Shared constants and types for the Montgomery multiplier datapath.
package mont_pkg;

  localparam int unsigned Q       = 3329;
  localparam int unsigned COEFF_W = 12;

  typedef logic [COEFF_W-1:0] coeff_t;

endpackage

// File: rtl/mont_res_fifo.sv
// Synchronous first-word fall-through FIFO holding multiplier results.
// The pointers carry one extra wrap bit so that full and empty are distinguishable.
module mont_res_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned AW = CNT_W - 1;

  logic [CNT_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // When full, a push is only taken alongside a pop; the slot being freed is the one written.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + CNT_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + CNT_W'(1);
    end
  end

  // Storage write; cleared on reset so the head reads zero when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/mont_mul_stream.sv
// Valid/ready front-end and back-end for the pipelined Montgomery multiplier.
// Credits reserve a FIFO slot per accepted operation so results are never dropped.
module mont_mul_stream
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH = COEFF_W,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_a,
  input  logic [WIDTH-1:0] s_b,
  output logic             mul_en,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_result,
  input  logic             mul_valid,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             busy,
  output logic             err
);

  logic [CNT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0] in_flight_q, in_flight_d;
  logic             mul_en_q, err_q, err_d;
  logic [WIDTH-1:0] mul_a_q, mul_b_q;
  logic             accept, pop, mul_ret, fifo_push, fifo_full, fifo_empty;

  assign s_ready = (credit_q != '0);
  assign accept  = s_valid & s_ready;
  assign pop     = m_valid & m_ready;
  assign m_valid = ~fifo_empty;
  assign busy    = (credit_q != CNT_W'(DEPTH));
  assign mul_en  = mul_en_q;
  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign err     = err_q;

  // A result only counts if an operation is outstanding; stray strobes are dropped.
  assign mul_ret   = mul_valid & (in_flight_q != '0);
  assign fifo_push = mul_ret & (~fifo_full | pop);

  // Next-state for credit, in-flight count and sticky error.
  always_comb begin
    credit_d    = credit_q;
    in_flight_d = in_flight_q;
    err_d       = err_q;
    case ({accept, pop})
      2'b10:   credit_d = credit_q - CNT_W'(1);
      2'b01:   credit_d = credit_q + CNT_W'(1);
      default: credit_d = credit_q;
    endcase
    case ({mul_en_q, mul_ret})
      2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
      2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
    if (mul_valid && ((in_flight_q == '0) || (fifo_full && !pop))) begin
      err_d = 1'b1;
    end
  end

  // State registers for credit, in-flight count and error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q    <= CNT_W'(DEPTH);
      in_flight_q <= '0;
      err_q       <= 1'b0;
    end else begin
      credit_q    <= credit_d;
      in_flight_q <= in_flight_d;
      err_q       <= err_d;
    end
  end

  // Issue stage: register the accepted pair towards the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_en_q <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else begin
      mul_en_q <= accept;
      if (accept) begin
        mul_a_q <= s_a;
        mul_b_q <= s_b;
      end
    end
  end

  mont_res_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (pop),
    .wdata (mul_result),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (m_data)
  );

endmodule

// File: tb/tb_mont_mul_stream.sv
// Directed bench for mont_mul_stream with a latency-4 (a+b) mod 4096 multiplier model.
module tb_mont_mul_stream;

  localparam int W = 12;

  logic         clk, rst_n;
  logic         s_valid, s_ready, mul_en, mul_valid, m_valid, m_ready, busy, err;
  logic [W-1:0] s_a, s_b, mul_a, mul_b, mul_result, m_data;

  logic         inj_valid;
  logic [W-1:0] inj_data;

  logic         f_push, f_pop, f_full, f_empty;
  logic [W-1:0] f_wdata, f_rdata;

  logic [3:0]   pipe_v;
  logic [W-1:0] pipe_d [4];

  int n_cmp = 0;
  int n_err = 0;

  mont_mul_stream #(
    .WIDTH (W),
    .DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_a        (s_a),
    .s_b        (s_b),
    .mul_en     (mul_en),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .mul_valid  (mul_valid),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .err        (err)
  );

  // Stand-alone FIFO instance for the full push+pop case.
  mont_res_fifo #(
    .WIDTH (W),
    .DEPTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (f_push),
    .pop   (f_pop),
    .wdata (f_wdata),
    .full  (f_full),
    .empty (f_empty),
    .rdata (f_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: 4-stage pipeline, flushed by the shared reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < 4; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v    <= {pipe_v[2:0], mul_en};
      pipe_d[0] <= mul_a + mul_b;
      for (int i = 1; i < 4; i++) pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign mul_valid  = pipe_v[3] | inj_valid;
  assign mul_result = inj_valid ? inj_data : pipe_d[3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, rcv, acc, n;

    rst_n     = 1'b0;
    s_valid   = 1'b1;
    s_a       = 12'd5;
    s_b       = 12'd7;
    m_ready   = 1'b1;
    inj_valid = 1'b0;
    inj_data  = '0;
    f_push    = 1'b0;
    f_pop     = 1'b0;
    f_wdata   = '0;

    // 1. Reset values while s_valid is held high.
    repeat (3) tick();
    check_eq("rst_s_ready", s_ready, 1);
    check_eq("rst_mul_en", mul_en, 0);
    check_eq("rst_mul_a", mul_a, 0);
    check_eq("rst_mul_b", mul_b, 0);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);

    // 2. First edge after reset accepts 5+7.
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    s_valid = 1'b0;
    check_eq("single_mul_en", mul_en, 1);
    check_eq("single_mul_a", mul_a, 5);
    check_eq("single_mul_b", mul_b, 7);
    check_eq("single_busy", busy, 1);
    repeat (4) tick();
    check_eq("single_early_m_valid", m_valid, 0);
    tick();
    check_eq("single_m_valid", m_valid, 1);
    check_eq("single_m_data", m_data, 12);
    tick();
    check_eq("single_busy_done", busy, 0);
    check_eq("single_m_valid_done", m_valid, 0);

    // 3. Stream of 64 pairs with the sink always ready.
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 300 && rcv < 64; cyc++) begin
      if (m_valid) begin
        check_eq("stream_data", m_data, 32'(3 * rcv));
        rcv++;
      end
      if (sent < 64) begin
        check_eq("stream_s_ready", s_ready, 1);
        s_valid = 1'b1;
        s_a     = W'(sent);
        s_b     = W'(2 * sent);
        if (s_ready) sent++;
      end else begin
        s_valid = 1'b0;
      end
      tick();
    end
    s_valid = 1'b0;
    check_eq("stream_count", rcv, 64);
    tick();
    check_eq("stream_err", err, 0);
    check_eq("stream_busy", busy, 0);

    // 4. Back-pressure: exactly 8 accepts, then one pop frees one credit.
    m_ready = 1'b0;
    s_valid = 1'b1;
    acc     = 0;
    for (int k = 0; k < 20; k++) begin
      s_a = W'(100 + acc);
      s_b = W'(acc);
      if (s_ready) acc++;
      tick();
    end
    check_eq("bp_accepts", acc, 8);
    check_eq("bp_s_ready", s_ready, 0);
    check_eq("bp_m_valid", m_valid, 1);
    check_eq("bp_head", m_data, 100);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check_eq("bp_s_ready_after_pop", s_ready, 1);
    check_eq("bp_head_after_pop", m_data, 102);
    s_a = W'(108);
    s_b = W'(8);
    tick();
    s_valid = 1'b0;
    check_eq("bp_s_ready_refull", s_ready, 0);
    check_eq("bp_extra_mul_en", mul_en, 1);
    check_eq("bp_extra_mul_a", mul_a, 108);
    repeat (8) tick();
    check_eq("bp_head_stable", m_data, 102);
    check_eq("bp_err", err, 0);
    m_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 20 && n < 8; cyc++) begin
      if (m_valid) begin
        check_eq("bp_drain_data", m_data, 32'(102 + 2 * n));
        n++;
      end
      tick();
    end
    check_eq("bp_drain_count", n, 8);
    tick();
    check_eq("bp_drain_empty", m_valid, 0);
    check_eq("bp_drain_busy", busy, 0);

    // 5. Full FIFO with simultaneous push and pop keeps occupancy and data.
    for (int k = 0; k < 8; k++) begin
      f_push  = 1'b1;
      f_wdata = W'(10 + k);
      tick();
    end
    f_push = 1'b0;
    check_eq("fifo_full", f_full, 1);
    check_eq("fifo_head", f_rdata, 10);
    f_push  = 1'b1;
    f_pop   = 1'b1;
    f_wdata = W'(99);
    tick();
    f_push = 1'b0;
    f_pop  = 1'b0;
    check_eq("fifo_pp_full", f_full, 1);
    check_eq("fifo_pp_head", f_rdata, 11);
    for (int k = 0; k < 8; k++) begin
      check_eq("fifo_pp_drain", f_rdata, (k < 7) ? 32'(11 + k) : 32'd99);
      f_pop = 1'b1;
      tick();
    end
    f_pop = 1'b0;
    check_eq("fifo_pp_empty", f_empty, 1);
    check_eq("fifo_pp_err", err, 0);

    // 6. Stray mul_valid with nothing in flight sets a sticky error.
    inj_valid = 1'b1;
    inj_data  = 12'hABC;
    tick();
    inj_valid = 1'b0;
    check_eq("inj_err", err, 1);
    check_eq("inj_fifo_empty", m_valid, 0);
    repeat (3) tick();
    check_eq("inj_err_sticky", err, 1);
    check_eq("inj_fifo_still_empty", m_valid, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check_eq("inj_err_async_clear", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("inj_err_after_reset", err, 0);
    check_eq("inj_s_ready_after_reset", s_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mont_mul_stream.md
# mont_mul_stream

Streaming front-end/back-end for the pipelined Montgomery multiplier. It accepts operand pairs on a valid/ready input port and issues them to the multiplier's `en`/`a`/`b` interface. It captures the multiplier's `result`/`valid` stream into an output FIFO and presents results on a valid/ready output port. A credit counter guarantees that every issued operation has a FIFO slot reserved, so results are never dropped regardless of multiplier latency.

## Interface
Parameters:
- `WIDTH`, 12: operand/result width (coefficients mod q = 3329).
- `DEPTH`, 8: output FIFO depth and maximum outstanding operations. Must be a power of two, ≥ 2.
- `CNT_W`, `$clog2(DEPTH)+1`: derived counter width. Not overridden.

Ports (one clock; reset is asynchronous and active-low, ports `clk` and `rst_n`):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `s_valid` in 1: input operand pair valid.
- `s_ready` out 1: block can accept a pair.
- `s_a`, `s_b` in WIDTH each: operands.
- `mul_en` out 1: issue strobe to multiplier.
- `mul_a`, `mul_b` out WIDTH each: operands to multiplier.
- `mul_result` in WIDTH: multiplier result.
- `mul_valid` in 1: multiplier result valid.
- `m_valid` out 1: output result valid.
- `m_ready` in 1: downstream accepts result.
- `m_data` out WIDTH: result at FIFO head.
- `busy` out 1: any operation in flight or buffered.
- `err` out 1: sticky protocol error.

## Operation
- `credit` register: reset value DEPTH.
  - Decrements on accept (`s_valid & s_ready`).
  - Increments on pop (`m_valid & m_ready`).
  - Accept and pop in the same cycle leave it unchanged.
  - `s_ready = (credit != 0)`, decoded from a register. It does not depend on `s_valid`.
- Issue stage (registered):
  - `mul_en <= s_valid & s_ready`.
  - On accept, `mul_a <= s_a` and `mul_b <= s_b`. Otherwise they hold their last values.
- `in_flight` counter:
  - Increments when `mul_en` is high.
  - Decrements on `mul_valid`.
  - Both in the same cycle leave it unchanged.
- Output FIFO:
  - Circular buffer, DEPTH entries, write/read pointers of CNT_W bits; the MSB is the wrap bit.
  - Full when the pointers differ only in the MSB. Empty when the pointers are equal.
  - Written with `mul_result` on `mul_valid`. Popped on `m_valid & m_ready`.
  - Push and pop in the same cycle are legal at every occupancy, including full.
  - `m_valid = !empty`. `m_data` is the head entry (first-word fall-through, read combinationally from the storage array).
- Order: results leave in issue order. The multiplier is in-order.
- `busy = (credit != DEPTH)`.
- Errors (`err`, sticky until reset):
  - `mul_valid` while `in_flight == 0`: the result is dropped and `err` is set.
  - `mul_valid` while the FIFO is full without a same-cycle pop: the result is dropped and `err` is set.
  - Neither case is reachable with a conforming multiplier.
- Reset values: `s_ready` = 1, `mul_en` = 0, `mul_a` = 0, `mul_b` = 0, `m_valid` = 0, `m_data` = 0 (storage cleared), `busy` = 0, `err` = 0. Pointers, `credit` and `in_flight` are also reset.
- Reset mid-operation: all state clears immediately. The multiplier must share `rst_n` so that its pipeline flushes; any stale `mul_valid` afterwards sets `err`.

## Timing
- Accept at edge N → `mul_en`/`mul_a`/`mul_b` valid in cycle N+1.
- `mul_valid` at edge M → `m_valid` high in cycle M+1 if the FIFO was empty.
- Total latency accept→`m_valid` = multiplier latency + 2.
- Throughput: one operation per cycle sustained while `m_ready` stays high and DEPTH ≥ multiplier latency + 2.
- `s_ready` falls in the cycle after the accept that brings `credit` to 0. It rises in the cycle after the pop that makes `credit` nonzero.
- `m_data` stays stable while `m_valid & !m_ready`.

## Structure
- Shared package `mont_pkg`: `Q = 3329`, `COEFF_W = 12`, typedef `coeff_t`. WIDTH defaults to `COEFF_W`.
- One sub-module: `mont_res_fifo`, the synchronous FIFO (push, pop, full, empty, head data).
- Credit, issue and error logic stay in the top level.

## Test plan
The bench pairs the block with a behavioural multiplier model of latency 4 that returns `(a+b) mod 4096`.
1. Reset with `s_valid` = 1 asserted → all outputs hold their reset values; the first accept occurs on the first edge after `rst_n` rises.
2. Single pair a=5, b=7 with `m_ready` = 1 → `mul_en` one cycle after accept; `m_valid` with `m_data` = 12 six cycles after accept; `busy` returns to 0.
3. Stream of 64 pairs a=i, b=2i with `m_ready` = 1, DEPTH = 8 → `s_ready` stays 1 throughout; outputs 3i in order; no `err`.
4. `m_ready` = 0 while streaming → exactly 8 accepts, then `s_ready` = 0; FIFO fills to 8. Raise `m_ready` for one cycle → one pop, `s_ready` = 1 the next cycle, one further accept.
5. Full FIFO with a same-cycle `mul_valid` and pop → data is preserved, occupancy stays 8, `err` = 0.
6. Inject `mul_valid` with no operation in flight → `err` = 1 and stays 1; FIFO is unchanged; `err` = 0 after `rst_n` pulse.
